// File: rtl/bar_height_gen.sv
// Spectrum bar height generator: folds band magnitudes into per-band targets and
// refreshes bar heights once per frame. Define BAR_PEAK_HOLD_EN for peak-hold markers.
module bar_height_gen #(
   parameter int NUM_BARS   = 10,
   parameter int MAG_W      = 16,
   parameter int SHIFT      = 6,
   parameter int MAX_H      = 400,
   parameter int DECAY_STEP = 4
) (
   input  logic                    Clk,
   input  logic                    Reset_n,
   input  logic                    frame_clk,
   input  logic                    Mag_valid,
   output logic                    Mag_ready,
   input  logic [3:0]              Mag_band,
   input  logic [MAG_W-1:0]        Mag_data,
   output logic [10*NUM_BARS-1:0]  Bar_H,
   output logic [10*NUM_BARS-1:0]  Peak_H,
   output logic                    Update_done
);

   localparam int IDX_W = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BARS - 1);

   typedef enum logic {S_ACCEPT, S_UPDATE} state_t;

   function automatic logic [9:0] f_sat_height(input logic [MAG_W-1:0] mag);
      logic [MAG_W-1:0] shifted;
      shifted = mag >> SHIFT;
      if (shifted > MAG_W'(MAX_H)) return 10'(MAX_H);
      else return shifted[9:0];
   endfunction

   // Fall by DECAY_STEP but never below fl (also prevents unsigned wrap).
   function automatic logic [9:0] f_decay(input logic [9:0] v, input logic [9:0] fl);
      logic [10:0] lim;
      lim = {1'b0, fl} + 11'(DECAY_STEP);
      if ({1'b0, v} >= lim) return v - 10'(DECAY_STEP);
      else return fl;
   endfunction

   state_t           r_state;
   logic             r_ready;
   logic             r_done;
   logic             r_frame_d;
   logic             r_pending;
   logic [IDX_W-1:0] r_idx;
   logic [9:0]       r_bar [NUM_BARS];
   logic [9:0]       r_tgt [NUM_BARS];
`ifdef BAR_PEAK_HOLD_EN
   logic [9:0]       r_peak [NUM_BARS];
   logic [4:0]       r_hold [NUM_BARS];
   logic [9:0]       w_cur_peak;
   logic [4:0]       w_cur_hold;
`endif

   logic       w_tick;
   logic       w_accept;
   logic       w_band_ok;
   logic [9:0] w_h;
   logic [9:0] w_cur_bar;
   logic [9:0] w_cur_tgt;
   logic [9:0] w_new_bar;

   assign w_tick    = frame_clk & ~r_frame_d;
   assign w_accept  = Mag_valid & r_ready;
   assign w_band_ok = {28'd0, Mag_band} < 32'(NUM_BARS);
   assign w_h       = f_sat_height(Mag_data);

   always_comb begin
      w_cur_bar = '0;
      w_cur_tgt = '0;
`ifdef BAR_PEAK_HOLD_EN
      w_cur_peak = '0;
      w_cur_hold = '0;
`endif
      for (int i = 0; i < NUM_BARS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_cur_bar = r_bar[i];
            w_cur_tgt = r_tgt[i];
`ifdef BAR_PEAK_HOLD_EN
            w_cur_peak = r_peak[i];
            w_cur_hold = r_hold[i];
`endif
         end
      end
   end

   assign w_new_bar = (w_cur_tgt >= w_cur_bar) ? w_cur_tgt : f_decay(w_cur_bar, 10'd0);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state   <= S_ACCEPT;
         r_ready   <= 1'b1;
         r_done    <= 1'b0;
         r_frame_d <= 1'b0;
         r_pending <= 1'b0;
         r_idx     <= '0;
         for (int i = 0; i < NUM_BARS; i++) begin
            r_bar[i] <= '0;
            r_tgt[i] <= '0;
`ifdef BAR_PEAK_HOLD_EN
            r_peak[i] <= '0;
            r_hold[i] <= '0;
`endif
         end
      end else begin
         r_frame_d <= frame_clk;
         r_done    <= 1'b0;
         case (r_state)
            S_ACCEPT: begin
               for (int i = 0; i < NUM_BARS; i++) begin
                  if (w_accept && w_band_ok && (Mag_band == 4'(i)) && (w_h > r_tgt[i]))
                     r_tgt[i] <= w_h;
               end
               if (w_tick) begin
                  r_state <= S_UPDATE;
                  r_ready <= 1'b0;
                  r_idx   <= '0;
               end
            end
            S_UPDATE: begin
               for (int i = 0; i < NUM_BARS; i++) begin
                  if (r_idx == IDX_W'(i)) begin
                     r_bar[i] <= w_new_bar;
                     r_tgt[i] <= '0;
`ifdef BAR_PEAK_HOLD_EN
                     if (w_new_bar >= w_cur_peak) begin
                        r_peak[i] <= w_new_bar;
                        r_hold[i] <= 5'd30;
                     end else if (w_cur_hold != 5'd0) begin
                        r_hold[i] <= w_cur_hold - 5'd1;
                     end else begin
                        r_peak[i] <= f_decay(w_cur_peak, w_new_bar);
                     end
`endif
                  end
               end
               // A tick seen anywhere in this pass (queued or on the last cycle) restarts it.
               if (r_idx == LAST_IDX) begin
                  r_done <= 1'b1;
                  r_idx  <= '0;
                  if (r_pending || w_tick) begin
                     r_pending <= 1'b0;
                  end else begin
                     r_state <= S_ACCEPT;
                     r_ready <= 1'b1;
                  end
               end else begin
                  r_idx <= r_idx + 1'b1;
                  if (w_tick) r_pending <= 1'b1;
               end
            end
            default: begin
               r_state <= S_ACCEPT;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign Mag_ready   = r_ready;
   assign Update_done = r_done;

   for (genvar g = 0; g < NUM_BARS; g++) begin : g_out
      assign Bar_H[10*g +: 10]  = r_bar[g];
`ifdef BAR_PEAK_HOLD_EN
      assign Peak_H[10*g +: 10] = r_peak[g];
`else
      assign Peak_H[10*g +: 10] = r_bar[g];
`endif
   end

endmodule

// File: tb/tb_bar_height_gen.sv
// Directed bench for bar_height_gen; peak-hold checks build when BAR_PEAK_HOLD_EN is defined.
module tb_bar_height_gen;

   localparam int N = 10;

   logic           Clk;
   logic           Reset_n;
   logic           frame_clk;
   logic           Mag_valid;
   logic           Mag_ready;
   logic [3:0]     Mag_band;
   logic [15:0]    Mag_data;
   logic [10*N-1:0] Bar_H;
   logic [10*N-1:0] Peak_H;
   logic           Update_done;

   int n_chk = 0;
   int n_err = 0;

   bar_height_gen #(.NUM_BARS(N)) dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .frame_clk   (frame_clk),
      .Mag_valid   (Mag_valid),
      .Mag_ready   (Mag_ready),
      .Mag_band    (Mag_band),
      .Mag_data    (Mag_data),
      .Bar_H       (Bar_H),
      .Peak_H      (Peak_H),
      .Update_done (Update_done)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] bar(input int i);
      return Bar_H[10*i +: 10];
   endfunction

   function automatic logic [9:0] peak(input int i);
      return Peak_H[10*i +: 10];
   endfunction

   task automatic do_reset();
      Reset_n = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      Reset_n = 1'b1;
   endtask

   task automatic send(input logic [3:0] b, input logic [15:0] d);
      Mag_valid = 1'b1;
      Mag_band  = b;
      Mag_data  = d;
      @(posedge Clk);
      #1;
      Mag_valid = 1'b0;
   endtask

   // Raise frame_clk (optionally with a sample on the same cycle), extra ticks at
   // cycles xt1/xt2, and observe a fixed window counting busy cycles and done pulses.
   task automatic run_frame(input int xt1, input int xt2, input logic sv,
                            input logic [3:0] sb, input logic [15:0] sd,
                            output int low, output int pulses, output int first_done);
      low = 0;
      pulses = 0;
      first_done = 0;
      frame_clk = 1'b1;
      if (sv) begin
         Mag_valid = 1'b1;
         Mag_band  = sb;
         Mag_data  = sd;
      end
      for (int k = 1; k <= 3*N + 5; k++) begin
         @(posedge Clk);
         #1;
         if (k == 1) begin
            frame_clk = 1'b0;
            Mag_valid = 1'b0;
         end
         if (xt1 != 0 && k == xt1) frame_clk = 1'b1;
         if (xt2 != 0 && k == xt2) frame_clk = 1'b1;
         if (xt1 != 0 && k == xt1 + 1) frame_clk = 1'b0;
         if (xt2 != 0 && k == xt2 + 1) frame_clk = 1'b0;
         if (!Mag_ready) low++;
         if (Update_done) begin
            pulses++;
            if (first_done == 0) first_done = k;
         end
      end
   endtask

   task automatic frame();
      int lo, pu, fd;
      run_frame(0, 0, 1'b0, 4'd0, 16'd0, lo, pu, fd);
   endtask

   initial begin
      int lo, pu, fd;
      logic [10*N-1:0] e;
      logic [10*N-1:0] snap;
      frame_clk = 1'b0;
      Mag_valid = 1'b0;
      Mag_band  = 4'd0;
      Mag_data  = 16'd0;
      do_reset();

      chk("reset_ready", Mag_ready, 1);
      chk("reset_bar", Bar_H, 0);
      chk("reset_peak", Peak_H, 0);
      chk("reset_done", Update_done, 0);

      send(4'd0, 16'h1900);
      run_frame(0, 0, 1'b0, 4'd0, 16'd0, lo, pu, fd);
      chk("f1_low", lo, N);
      chk("f1_pulses", pu, 1);
      chk("f1_done_cycle", fd, N + 1);
      chk("f1_bar0", bar(0), 100);
`ifndef BAR_PEAK_HOLD_EN
      chk("f1_peak_eq_bar", Peak_H, Bar_H);
`endif

      snap = Bar_H;
      repeat (5) @(posedge Clk);
      #1;
      send(4'd5, 16'h0000);
      chk("accept_stable", Bar_H, snap);

      send(4'd3, 16'hFFFF);
      frame();
      chk("f2_bar3_sat", bar(3), 400);
      chk("f2_bar0_decay", bar(0), 96);

      repeat (3) frame();
      chk("f5_bar3", bar(3), 388);
      chk("f5_bar0", bar(0), 84);

      send(4'd2, 16'h0400);
      send(4'd2, 16'h0C80);
      frame();
      chk("f6_bar2_max", bar(2), 50);

      send(4'd2, 16'h0C80);
      send(4'd2, 16'h0400);
      frame();
      chk("f7_bar2_max_rev", bar(2), 50);

      send(4'd12, 16'hFFFF);
      send(4'd10, 16'hFFFF);
      frame();
      e = '0;
      e[9:0]   = 10'd72;
      e[29:20] = 10'd46;
      e[39:30] = 10'd376;
      chk("f8_oob_bands", Bar_H, e);

      send(4'd9, 16'h0FC0);
      send(4'd5, 16'h003F);
      send(4'd4, 16'h0080);
      frame();
      chk("f9_bar9_last", bar(9), 63);
      chk("f9_bar5_small", bar(5), 0);
      chk("f9_bar4", bar(4), 2);

      run_frame(5, 8, 1'b0, 4'd0, 16'd0, lo, pu, fd);
      chk("f10_low_2n", lo, 2*N);
      chk("f10_pulses", pu, 2);
      chk("f10_bar4_floor", bar(4), 0);
      chk("f10_bar0", bar(0), 60);
      chk("f10_bar9", bar(9), 55);

      run_frame(0, 0, 1'b1, 4'd7, 16'h1000, lo, pu, fd);
      chk("f11_tick_sample", bar(7), 64);
      chk("f11_pulses", pu, 1);

`ifdef BAR_PEAK_HOLD_EN
      do_reset();
      send(4'd1, 16'h3200);
      frame();
      chk("ph_bar1", bar(1), 200);
      chk("ph_peak1", peak(1), 200);
      for (int f = 1; f <= 32; f++) begin
         frame();
         chk("ph_peak_ge_bar", peak(1) >= bar(1), 1);
         if (f == 30) chk("ph_hold30", peak(1), 200);
         if (f == 31) chk("ph_fall1", peak(1), 196);
         if (f == 32) chk("ph_fall2", peak(1), 192);
      end
      chk("ph_bar1_end", bar(1), 72);
`endif

      send(4'd1, 16'h3200);
      frame_clk = 1'b1;
      @(posedge Clk);
      #1;
      frame_clk = 1'b0;
      repeat (4) @(posedge Clk);
      #3;
      chk("mid_bar1", bar(1), 200);
      chk("mid_busy", Mag_ready, 0);
      Reset_n = 1'b0;
      #1;
      chk("rst_mid_bar", Bar_H, 0);
      chk("rst_mid_peak", Peak_H, 0);
      chk("rst_mid_ready", Mag_ready, 1);
      chk("rst_mid_done", Update_done, 0);
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      run_frame(0, 0, 1'b0, 4'd0, 16'd0, lo, pu, fd);
      chk("post_rst_bar", Bar_H, 0);
      chk("post_rst_pulses", pu, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/bar_height_gen.md
BAR_HEIGHT_GEN -- requirements
Module: bar_height_gen

Interface
REQ-001 Parameter NUM_BARS, default 10: number of spectrum bars/bands.
REQ-002 Parameter MAG_W, default 16: magnitude input width, unsigned.
REQ-003 Parameter SHIFT, default 6: magnitude-to-pixel right shift.
REQ-004 Parameter MAX_H, default 400: height saturation limit in pixels.
REQ-005 Parameter DECAY_STEP, default 4: pixels a bar falls per frame.
REQ-006 Ports, in order:
- Clk  in  1  system clock; one clock domain; all logic on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_clk  in  1  vertical-sync level, synchronous to Clk.
- Mag_valid  in  1  magnitude sample valid.
- Mag_ready  out  1  block can accept a sample.
- Mag_band  in  4  band index of the sample.
- Mag_data  in  MAG_W  unsigned band magnitude.
- Bar_H  out  10*NUM_BARS  bar heights in pixels; band i in bits [10i+9:10i].
- Peak_H  out  10*NUM_BARS  peak-marker heights; same packing as Bar_H.
- Update_done  out  1  one-cycle pulse when a frame update completes.

Function
REQ-007 A sample transfers on a cycle where Mag_valid and Mag_ready are both 1.
REQ-008 Conversion: h = min(Mag_data >> SHIFT, MAX_H), computed at 10 bits with saturation before truncation.
REQ-009 Each band has a target register; an accepted sample sets target[band] = max(target[band], h).
REQ-010 A sample with Mag_band >= NUM_BARS is accepted and discarded, with no state change.
REQ-011 A frame tick is a rising edge of frame_clk, detected with a one-cycle delayed copy.
REQ-012 The FSM has two states:
- ACCEPT: Mag_ready = 1.
- UPDATE: Mag_ready = 0.
REQ-013 ACCEPT -> UPDATE on the cycle a frame tick is detected. A sample accepted on that same cycle is included in this frame's update.
REQ-014 UPDATE processes one band per cycle, index 0 to NUM_BARS-1, taking exactly NUM_BARS cycles, then returns to ACCEPT.
REQ-015 Per processed band i:
- if target[i] >= Bar_H[i], Bar_H[i] <= target[i];
- else Bar_H[i] <= Bar_H[i] - DECAY_STEP, floored at 0 (no underflow wrap);
- target[i] <= 0 in the same cycle.
REQ-016 Update_done pulses high for one cycle on the UPDATE -> ACCEPT transition.
REQ-017 A frame tick detected during UPDATE sets a pending flag. On leaving UPDATE, the FSM enters UPDATE again immediately and clears the flag. At most one tick is queued; further ticks are dropped.
REQ-018 Bar_H and Peak_H change only during UPDATE and remain stable for the rest of the frame.
REQ-019 Without the Configuration feature, Peak_H = Bar_H.

Reset
REQ-020 Reset_n low asynchronously clears all registers:
- Bar_H, Peak_H, all targets, hold counters, pending flag, edge register = 0;
- Update_done = 0;
- FSM = ACCEPT, so Mag_ready = 1 after reset.
REQ-021 Reset asserted mid-UPDATE aborts the update; no partially updated band values are retained.

Configuration
REQ-022 Macro BAR_PEAK_HOLD_EN, when defined, adds a per-band peak marker and a 5-bit hold counter.
- In UPDATE, if the new Bar_H[i] >= Peak_H[i]: Peak_H[i] <= new Bar_H[i] and hold[i] <= 30.
- Otherwise, if hold[i] != 0, hold[i] decrements.
- Otherwise, Peak_H[i] falls by DECAY_STEP, floored at the new Bar_H[i].
REQ-023 When BAR_PEAK_HOLD_EN is undefined, the peak-hold registers are not synthesized and Peak_H follows REQ-019.

Verification
REQ-024 After reset release, with no samples:
- response: Mag_ready = 1; all Bar_H and Peak_H = 0.
REQ-025 Sample band 0, Mag_data = 16'h1900, then one frame tick:
- response: Bar_H[0] = 100, exactly NUM_BARS cycles after the tick is detected;
- Update_done pulses once.
REQ-026 Sample band 3, Mag_data = 16'hFFFF:
- response: Bar_H[3] = 400 (saturated).
- Then 3 further ticks with no samples: Bar_H[3] = 388.
REQ-027 Band 2 receives samples 16'h0400 then 16'h0C80 in one frame:
- response: Bar_H[2] = 50 (maximum kept).
- Mag_band = 12: no bar changes.
REQ-028 Second frame tick during UPDATE:
- response: a second UPDATE runs back-to-back;
- Mag_ready is low for 2*NUM_BARS cycles;
- two Update_done pulses.
REQ-029 With BAR_PEAK_HOLD_EN defined: band 1 driven to 200, then silence.
- response: Peak_H[1] stays 200 for 30 frames, then falls 4 per frame;
- Peak_H[1] is never below Bar_H[1].
- Reset_n pulsed mid-UPDATE: all outputs return to 0.
